// File: rtl/crc_sched_pkg.sv
// Shared types and constants for the CRC byte scheduler and its serial CRC engine.
// Holds the FSM states, counter and index widths, and the engine seed/taps used by the reference model.
package crc_sched_pkg;

   localparam int DATA_W  = 8;
   localparam int CRC_W   = 8;
   localparam int OUT_LAT = 1;
   localparam int CNT_W   = 4;
   localparam int DIDX_W  = $clog2(DATA_W);
   localparam int CIDX_W  = $clog2(CRC_W);

   localparam logic [7:0] SEED = 8'hD8;
   localparam logic [7:0] TAPS = 8'h44;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      SHIFT,
      WAIT,
      CAPTURE,
      DONE
   } state_t;

endpackage

// File: rtl/crc_rr_arb2.sv
// Two-way round-robin arbiter: grants are combinational while en is high, zero latency.
// On a tie, the requester that did not win last time is granted; a losing requester simply keeps waiting.
module crc_rr_arb2
   import crc_sched_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       REQ0,
   input  logic       REQ1,
   input  logic       en,
   output logic [1:0] gnt
);

   logic rr_last;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (REQ0 && REQ1) gnt = rr_last ? 2'b01 : 2'b10;
         else              gnt = {REQ1, REQ0};
      end
   end

   // rr_last starts at 1 so requester 0 wins the first tie after reset
   always_ff @(posedge CLK) begin
      if (RST)         rr_last <= 1'b1;
      else if (gnt[1]) rr_last <= 1'b1;
      else if (gnt[0]) rr_last <= 1'b0;
   end

endmodule

// File: rtl/crc_byte_scheduler.sv
// Shares one serial CRC engine between two byte requesters: 20 cycles from accept to DONE.
// Requests are only accepted in IDLE; anything raised while busy waits for the next IDLE.
module crc_byte_scheduler
   import crc_sched_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ0,
   input  logic [DATA_W-1:0] DATA0,
   input  logic              REQ1,
   input  logic [DATA_W-1:0] DATA1,
   output logic              ACK0,
   output logic              ACK1,
   output logic              DONE,
   output logic              DONE_ID,
   output logic [CRC_W-1:0]  CRC_OUT,
   output logic              ERR,
   output logic              BUSY,
   output logic              ENG_RST_N,
   output logic              ENG_ACTIVE,
   output logic              ENG_DATA,
   input  logic              ENG_CRC,
   input  logic              ENG_VALID
);

   state_t             state, next_state;
   logic [CNT_W-1:0]   cnt, next_cnt;
   logic [1:0]         gnt;
   logic [DATA_W-1:0]  byte_q;
   logic               id_q;
   logic [CRC_W-1:0]   crc_q;
   logic               err_q;
   logic               eng_rst_n_q, eng_active_q, eng_data_q;

   crc_rr_arb2 u_arb (
      .CLK  (CLK),
      .RST  (RST),
      .REQ0 (REQ0),
      .REQ1 (REQ1),
      .en   (state == IDLE),
      .gnt  (gnt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:                if (|gnt) next_state = CLR;
         CLR:                 next_state = SHIFT;
         SHIFT:               if (cnt == CNT_W'(DATA_W - 1))  next_state = WAIT;
         WAIT:                if (cnt == CNT_W'(OUT_LAT - 1)) next_state = CAPTURE;
         CAPTURE:             if (cnt == CNT_W'(CRC_W - 1))   next_state = crc_sched_pkg::DONE;
         crc_sched_pkg::DONE: next_state = IDLE;
         default:             next_state = IDLE;
      endcase
   end

   // Counter restarts at zero on every state entry
   assign next_cnt = (next_state != state) ? '0 : cnt + CNT_W'(1);

   always_comb begin
      ACK0 = gnt[0];
      ACK1 = gnt[1];
      DONE = (state == crc_sched_pkg::DONE);
      BUSY = (state != IDLE);
   end

   // Engine controls are driven from next_state so they line up with the state they belong to
   always_ff @(posedge CLK) begin
      if (RST) begin
         byte_q       <= '0;
         id_q         <= 1'b0;
         crc_q        <= '0;
         err_q        <= 1'b0;
         eng_rst_n_q  <= 1'b0;
         eng_active_q <= 1'b0;
         eng_data_q   <= 1'b0;
      end else begin
         if (state == IDLE && |gnt) begin
            byte_q <= gnt[1] ? DATA1 : DATA0;
            id_q   <= gnt[1];
         end
         if (state == CAPTURE) crc_q[cnt[CIDX_W-1:0]] <= ENG_CRC;
         if (state == CAPTURE && cnt == '0 && !ENG_VALID) err_q <= 1'b1;
         eng_rst_n_q  <= (next_state != CLR);
         eng_active_q <= (next_state == SHIFT);
         eng_data_q   <= (next_state == SHIFT) && byte_q[next_cnt[DIDX_W-1:0]];
      end
   end

   assign DONE_ID    = id_q;
   assign CRC_OUT    = crc_q;
   assign ERR        = err_q;
   assign ENG_RST_N  = eng_rst_n_q;
   assign ENG_ACTIVE = eng_active_q;
   assign ENG_DATA   = eng_data_q;

endmodule

// File: tb/tb_crc_byte_scheduler.sv
// Bench for crc_byte_scheduler with a behavioural serial CRC engine and a result scoreboard.
`timescale 1ns/1ps
module tb_crc_byte_scheduler;
   import crc_sched_pkg::DATA_W;
   import crc_sched_pkg::CRC_W;
   import crc_sched_pkg::SEED;
   import crc_sched_pkg::TAPS;

   logic              CLK = 1'b0;
   logic              RST;
   logic              REQ0, REQ1;
   logic [DATA_W-1:0] DATA0, DATA1;
   logic              ACK0, ACK1, DONE, DONE_ID, ERR, BUSY;
   logic [CRC_W-1:0]  CRC_OUT;
   logic              ENG_RST_N, ENG_ACTIVE, ENG_DATA, ENG_CRC, ENG_VALID;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   crc_byte_scheduler dut (
      .CLK(CLK), .RST(RST), .REQ0(REQ0), .DATA0(DATA0), .REQ1(REQ1), .DATA1(DATA1),
      .ACK0(ACK0), .ACK1(ACK1), .DONE(DONE), .DONE_ID(DONE_ID), .CRC_OUT(CRC_OUT),
      .ERR(ERR), .BUSY(BUSY), .ENG_RST_N(ENG_RST_N), .ENG_ACTIVE(ENG_ACTIVE),
      .ENG_DATA(ENG_DATA), .ENG_CRC(ENG_CRC), .ENG_VALID(ENG_VALID)
   );

   function automatic logic [7:0] lfsr_step(input logic [7:0] c, input logic d);
      logic fb;
      fb = c[0] ^ d;
      return {fb, c[7:1]} ^ (fb ? TAPS : 8'h00);
   endfunction

   function automatic logic [7:0] golden(input logic [7:0] b);
      logic [7:0] c;
      c = SEED;
      for (int i = 0; i < 8; i++) c = lfsr_step(c, b[i]);
      return c;
   endfunction

   // Engine model: 8 shift cycles, one idle cycle, then 8 CRC bits LSB first with valid high
   logic [7:0] e_crc;
   logic [3:0] e_in, e_out;
   logic       e_bit, e_valid, stub_invalid;

   always @(posedge CLK) begin
      if (!ENG_RST_N) begin
         e_crc <= SEED; e_in <= 4'd0; e_out <= 4'd0; e_bit <= 1'b0; e_valid <= 1'b0;
      end else if (e_in < 4'd8) begin
         if (ENG_ACTIVE) begin
            e_crc <= lfsr_step(e_crc, ENG_DATA);
            e_in  <= e_in + 4'd1;
         end
      end else if (e_out < 4'd8) begin
         e_bit   <= e_crc[0];
         e_crc   <= {1'b0, e_crc[7:1]};
         e_out   <= e_out + 4'd1;
         e_valid <= 1'b1;
      end else begin
         e_valid <= 1'b0;
      end
   end

   assign ENG_CRC   = e_bit;
   assign ENG_VALID = e_valid && !stub_invalid;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic       id;
      logic [7:0] crc;
      int         acc;
      logic       err;
   } exp_t;
   exp_t sb[$];

   always @(negedge CLK) begin
      if ((ACK0 || ACK1) && !RST) chk("ack_outside_idle", BUSY, 0);
      if (DONE) begin
         if (sb.size() == 0) begin
            chk("done_expected", 0, 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_id", DONE_ID, e.id);
            chk("crc_out", CRC_OUT, e.crc);
            chk("done_latency", cyc - e.acc, 19);
            chk("err_at_done", ERR, e.err);
         end
      end
   end

   task automatic expect_accept(input logic exp_id, input logic [7:0] exp_crc,
                                input logic exp_err, output int acc);
      int n;
      exp_t e;
      n = 0;
      acc = cyc;
      while (!(ACK0 || ACK1) && n < 60) begin
         @(negedge CLK); #1;
         n++;
      end
      if (!(ACK0 || ACK1)) begin
         chk("ack_timeout", 0, 1);
      end else begin
         acc = cyc;
         chk("ack_id", ACK1, exp_id);
         chk("ack_onehot", ACK0 && ACK1, 0);
         e.id = exp_id; e.crc = exp_crc; e.acc = acc; e.err = exp_err;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() > 0 || BUSY) && n < 60) begin
         @(negedge CLK); #1;
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      sb.delete();
      @(negedge CLK); #1;
      RST = 1'b0;
   endtask

   typedef struct {
      logic       r0, r1;
      logic [7:0] d0, d1;
      logic       exp_id;
      logic [7:0] exp_crc;
   } vec_t;
   vec_t tbl[7];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int   a, a0;
      logic [7:0] b;

      tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h14};
      tbl[1] = '{1'b0, 1'b1, 8'h00, 8'hA5, 1'b1, golden(8'hA5)};
      tbl[2] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, golden(8'h3C)};
      tbl[3] = '{1'b1, 1'b1, 8'h3C, 8'hC3, 1'b1, golden(8'hC3)};
      tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h01, 1'b0, golden(8'hFF)};
      tbl[5] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, golden(8'hFF)};
      tbl[6] = '{1'b1, 1'b0, 8'h7E, 8'h00, 1'b0, golden(8'h7E)};

      RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; DATA0 = '0; DATA1 = '0; stub_invalid = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_ack0", ACK0, 0);
      chk("rst_ack1", ACK1, 0);
      chk("rst_done", DONE, 0);
      chk("rst_done_id", DONE_ID, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_err", ERR, 0);
      chk("rst_crc_out", CRC_OUT, 0);
      chk("rst_eng_active", ENG_ACTIVE, 0);
      chk("rst_eng_data", ENG_DATA, 0);
      chk("rst_eng_rst_n", ENG_RST_N, 0);
      RST = 1'b0;
      @(negedge CLK); #1;
      chk("idle_eng_rst_n", ENG_RST_N, 1);

      // Tie straight out of reset: requester 0 first, requester 1 exactly one job later
      REQ0 = 1'b1; REQ1 = 1'b1; DATA0 = 8'h00; DATA1 = 8'hA5;
      #1;
      expect_accept(1'b0, 8'h14, 1'b0, a0);
      @(negedge CLK); REQ0 = 1'b0; DATA0 = 8'hEE;
      #1;
      expect_accept(1'b1, golden(8'hA5), 1'b0, a);
      chk("tie_second_ack_cycle", a - a0, 20);
      @(negedge CLK); REQ1 = 1'b0; DATA1 = 8'h5A;
      drain();

      foreach (tbl[i]) begin
         drain();
         REQ0 = tbl[i].r0; REQ1 = tbl[i].r1; DATA0 = tbl[i].d0; DATA1 = tbl[i].d1;
         #1;
         expect_accept(tbl[i].exp_id, tbl[i].exp_crc, 1'b0, a);
         @(negedge CLK);
         REQ0 = 1'b0; REQ1 = 1'b0;
         DATA0 = 8'($urandom); DATA1 = 8'($urandom);
      end
      drain();

      // Alternation: REQ1 held throughout, REQ0 raised mid-job
      do_reset();
      REQ1 = 1'b1; DATA1 = 8'h11;
      #1;
      expect_accept(1'b1, golden(8'h11), 1'b0, a0);
      repeat (5) @(negedge CLK);
      REQ0 = 1'b1; DATA0 = 8'h22;
      #1;
      expect_accept(1'b0, golden(8'h22), 1'b0, a);
      chk("alt_second_ack_cycle", a - a0, 20);
      @(negedge CLK); REQ0 = 1'b0;
      #1;
      expect_accept(1'b1, golden(8'h11), 1'b0, a);
      chk("alt_third_ack_cycle", a - a0, 40);
      @(negedge CLK); REQ1 = 1'b0;
      drain();

      // Engine-side waveform for 0x81
      b = 8'h81;
      REQ0 = 1'b1; DATA0 = b;
      #1;
      expect_accept(1'b0, golden(b), 1'b0, a);
      for (int k = 1; k <= 11; k++) begin
         @(negedge CLK); #1;
         REQ0 = 1'b0;
         chk($sformatf("eng_active_c%0d", k), ENG_ACTIVE, (k >= 2 && k <= 9));
         if (k >= 2 && k <= 9) chk($sformatf("eng_data_c%0d", k), ENG_DATA, b[k-2]);
         if (k <= 2) chk($sformatf("eng_rst_n_c%0d", k), ENG_RST_N, (k == 2));
      end
      drain();

      // Reset in CAPTURE cycle 3 drops the job
      REQ0 = 1'b1; DATA0 = 8'h5A;
      #1;
      expect_accept(1'b0, golden(8'h5A), 1'b0, a);
      @(negedge CLK); REQ0 = 1'b0;
      while (cyc < a + 14) @(negedge CLK);
      #1;
      chk("pre_reset_busy", BUSY, 1);
      RST = 1'b1;
      sb.delete();
      @(negedge CLK); #1;
      chk("midrst_eng_rst_n", ENG_RST_N, 0);
      chk("midrst_busy", BUSY, 0);
      chk("midrst_crc_out", CRC_OUT, 0);
      chk("midrst_done", DONE, 0);
      RST = 1'b0;
      repeat (25) @(negedge CLK);
      #1;
      REQ0 = 1'b1; DATA0 = 8'h00;
      #1;
      expect_accept(1'b0, 8'h14, 1'b0, a);
      @(negedge CLK); REQ0 = 1'b0;
      drain();

      // Engine valid held low: ERR sets at the end of cycle 11 and sticks
      stub_invalid = 1'b1;
      REQ0 = 1'b1; DATA0 = 8'h00;
      #1;
      expect_accept(1'b0, 8'h14, 1'b1, a);
      @(negedge CLK); REQ0 = 1'b0;
      while (cyc < a + 11) @(negedge CLK);
      #1;
      chk("err_before_capture_end", ERR, 0);
      @(negedge CLK); #1;
      chk("err_after_cycle11", ERR, 1);
      drain();
      stub_invalid = 1'b0;
      REQ1 = 1'b1; DATA1 = 8'hA5;
      #1;
      expect_accept(1'b1, golden(8'hA5), 1'b1, a);
      @(negedge CLK); REQ1 = 1'b0;
      drain();
      chk("err_sticky_idle", ERR, 1);
      do_reset();
      chk("err_cleared_by_rst", ERR, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_byte_scheduler.md
Name: crc_byte_scheduler

Overview:
Shares one serial 8-bit CRC engine (LFSR, seed 0xD8, taps 0x44, one data bit per cycle, then CRC shifted out serially) between two byte requesters.
- Arbitrates requests round-robin.
- Resets the engine and feeds it 8 data bits LSB first.
- Waits out the engine's output latency, deserialises the 8 CRC bits and returns them as a parallel result tagged with the requester ID.
- Sits between the requesting datapath blocks and the CRC engine instance.

Parameters:
DATA_W, 8, bits per request and bits fed to the engine; fixed to the engine's internal 8-bit counter.
CRC_W, 8, CRC bits captured from the engine's serial output.
OUT_LAT, 1, cycles between the last SHIFT cycle and the first valid serial CRC bit.

Ports:
CLK  in  1  single clock, all logic on the rising edge
RST  in  1  reset; synchronous, active-high
REQ0  in  1  requester 0 request; level, held until ACK0
DATA0  in  DATA_W  requester 0 byte; sampled on the ACK0 cycle
REQ1  in  1  requester 1 request
DATA1  in  DATA_W  requester 1 byte
ACK0  out  1  one-cycle accept pulse to requester 0
ACK1  out  1  one-cycle accept pulse to requester 1
DONE  out  1  one-cycle result pulse
DONE_ID  out  1  requester that owns the result
CRC_OUT  out  CRC_W  parallel CRC; bit k = k-th serial bit from the engine
ERR  out  1  sticky: engine valid was low at capture start; cleared by RST
BUSY  out  1  high in every state except IDLE
ENG_RST_N  out  1  engine reset, active-low
ENG_ACTIVE  out  1  engine shift enable
ENG_DATA  out  1  engine serial data bit
ENG_CRC  in  1  engine serial CRC bit
ENG_VALID  in  1  engine valid flag

Behaviour:
- Reset (RST high at an edge) gives: state IDLE, ACK0/ACK1/DONE/DONE_ID/BUSY/ERR = 0, CRC_OUT = 0, ENG_ACTIVE = 0, ENG_DATA = 0, ENG_RST_N = 0 (registered), rr_last = 1 so requester 0 wins first. Applies mid-operation: the in-flight job is dropped, no DONE is issued, the engine is held in reset.
- ENG_RST_N is 0 while in reset and in CLR, 1 otherwise. All ENG_* outputs are registered.
- State machine: IDLE -> CLR (1 cycle) -> SHIFT (DATA_W cycles) -> WAIT (OUT_LAT cycles) -> CAPTURE (CRC_W cycles) -> DONE (1 cycle) -> IDLE. Counters are 4-bit and reload on each state entry.
- IDLE accept rules:
  - ACKn is combinational: asserted in IDLE for the granted requester only.
  - One request: it wins.
  - Both requesting: the one not equal to rr_last wins.
  - On accept: latch the byte and ID, set rr_last = ID, go to CLR.
- SHIFT: ENG_ACTIVE = 1; ENG_DATA = byte[i] in SHIFT cycle i (i = 0..7, LSB first).
- WAIT: ENG_ACTIVE = 0.
- CAPTURE:
  - CRC_OUT[k] <= ENG_CRC at the end of CAPTURE cycle k.
  - In CAPTURE cycle 0, ENG_VALID == 0 sets ERR. The job still completes.
- DONE: DONE = 1 with DONE_ID. CRC_OUT holds its value until the next job's CAPTURE begins.
- Cycle budget: accept at cycle 0, CLR 1, SHIFT 2-9, WAIT 10, CAPTURE 11-18, DONE 19; 20 cycles per job. A new accept is possible at the earliest in cycle 20 (IDLE).
- A request raised during BUSY waits; no ACK is issued outside IDLE. A requester dropping REQ before ACK is legal and simply loses its slot.
- REQ/DATA changes during a job do not affect the latched byte.

Decomposition:
- Package crc_sched_pkg holds:
  - state enum: IDLE, CLR, SHIFT, WAIT, CAPTURE, DONE
  - DATA_W, CRC_W, OUT_LAT defaults
  - the engine SEED = 8'hD8 and TAPS = 8'h44 constants, for bench golden-model use
- One sub-module: crc_rr_arb2 (2-way round-robin arbiter with rr_last register; inputs REQ0/REQ1, accept enable; outputs grant vector). The FSM and deserialiser stay in the top.

Test Plan:
- REQ0 with DATA0 = 0x00, engine instantiated in the bench -> ACK0 in cycle 0, DONE in cycle 19, DONE_ID = 0, CRC_OUT = 0x14, ERR = 0.
- REQ0 and REQ1 raised together and held, bytes 0x00 and 0xA5 -> ACK0 at cycle 0 and ACK1 at cycle 20. DONE_IDs are 0 then 1. Second CRC_OUT matches the golden model for 0xA5.
- REQ1 held continuously, REQ0 pulsed during the first job -> grants alternate 1, 0, 1. No requester is starved for more than one job.
- RST asserted in CAPTURE cycle 3 -> no DONE issued. Next cycle: ENG_RST_N = 0, BUSY = 0, CRC_OUT = 0. A later REQ0 of 0x00 yields 0x14.
- Bench engine stub holds ENG_VALID = 0 -> ERR = 1 after cycle 11, stays set across the following jobs, cleared only by RST.
- ENG_DATA/ENG_ACTIVE monitor with DATA0 = 0x81 -> ENG_ACTIVE high for exactly cycles 2-9; ENG_DATA sequence 1,0,0,0,0,0,0,1.
